// File: rtl/alu_pkg.sv
// alu_pkg: op codes, widths and arbiter state encoding shared by the alu and its share arbiter.
package alu_pkg;
   localparam int ALU_OP_W = 4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = 4'd9;
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;
   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational integer alu; undefined op codes yield zero.
import alu_pkg::*;
module alu #(
   parameter int W = 32
) (
   input  logic [W-1:0]        a_i,
   input  logic [W-1:0]        b_i,
   input  logic [ALU_OP_W-1:0] op_i,
   output logic [W-1:0]        res_o
);
   always_comb begin
      res_o = '0;
      case (op_i)
         ALU_ADD:  res_o = a_i + b_i;
         ALU_SUB:  res_o = a_i - b_i;
         ALU_SLL:  res_o = a_i << b_i;
         ALU_SLT:  res_o = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: res_o = {{(W-1){1'b0}}, a_i < b_i};
         ALU_XOR:  res_o = a_i ^ b_i;
         ALU_SRL:  res_o = a_i >> b_i;
         ALU_SRA:  res_o = W'($signed(a_i) >>> b_i);
         ALU_OR:   res_o = a_i | b_i;
         ALU_AND:  res_o = a_i & b_i;
         default:  res_o = '0;
      endcase
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one alu between two requesters,
// with a single registered result held until its owner accepts it.
import alu_pkg::*;
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid_i,
   output logic [NUM_REQ-1:0]                   req_ready_o,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b_i,
   input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]     req_op_i,
   output logic [NUM_REQ-1:0]                   rsp_valid_o,
   input  logic [NUM_REQ-1:0]                   rsp_ready_i,
   output logic [DATA_WIDTH-1:0]                rsp_res_o,
   output logic                                 rsp_err_o
);
   arb_state_e            state;
   logic                  rr_ptr, owner, g, busy, accept;
   logic [DATA_WIDTH-1:0] alu_res;
   assign busy = state == ARB_BUSY;
   assign g = (&req_valid_i) ? rr_ptr : req_valid_i[1];
   // Accepting while busy is only allowed when the held result leaves this same edge.
   assign accept = ~rst & (~busy | rsp_ready_i[owner]) & (|req_valid_i);
   assign req_ready_o = {accept & g, accept & ~g};
   assign rsp_valid_o = {busy & owner, busy & ~owner};
   alu #(.W(DATA_WIDTH)) u_alu (
      .a_i   (req_a_i[g]),
      .b_i   (req_b_i[g]),
      .op_i  (req_op_i[g]),
      .res_o (alu_res)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         rr_ptr    <= 1'b0;
         owner     <= 1'b0;
         rsp_res_o <= '0;
         rsp_err_o <= 1'b0;
      end else if (accept) begin
         state     <= ARB_BUSY;
         owner     <= g;
         rr_ptr    <= ~g;
         rsp_res_o <= alu_res;
         rsp_err_o <= req_op_i[g] > ALU_OP_LAST;
      end else if (busy & rsp_ready_i[owner]) begin
         state <= ARB_IDLE;
      end
   end
endmodule
